csr_access_unit: RTL and testbench

Zicsr instruction sequencer on the initiating side of the CSR register file's read/write ports. It accepts one decoded CSR instruction at a time, performs the read-modify-write against the register file, and returns the old CSR value for rd. It also merges FPU exception flags into fcsr through the fcsr write port, so flag updates and software CSR accesses never race.

---
 rtl/csr_pkg.sv | 31 +++
 rtl/csr_rmw_alu.sv | 45 ++++
 rtl/csr_access_unit.sv | 184 ++++++++++++++++++
 tb/tb_csr_access_unit.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared types and constants for the CSR access sequencer.
// Holds the funct3 encodings, FSM states, float CSR addresses and the read-only space check.
package csr_pkg;

  localparam logic [11:0] CSR_FFLAGS = 12'h001;
  localparam logic [11:0] CSR_FRM    = 12'h002;
  localparam logic [11:0] CSR_FCSR   = 12'h003;

  typedef enum logic [2:0] {
    F3_RW  = 3'b001,
    F3_RS  = 3'b010,
    F3_RC  = 3'b011,
    F3_RWI = 3'b101,
    F3_RSI = 3'b110,
    F3_RCI = 3'b111
  } funct3_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  // Addresses whose top two bits are 2'b11 are read-only by architectural convention.
  function automatic logic csr_is_read_only(input logic [1:0] addr_space);
    return addr_space == 2'b11;
  endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// Combinational read-modify-write datapath for Zicsr instructions.
// Produces the new CSR value, whether a write happens, and whether the instruction is illegal.
module csr_rmw_alu
  import csr_pkg::*;
#(
  parameter int NUM_CSR_ADDR_BITS = 12,
  parameter int XLEN = 32
) (
  input  logic [2:0]                   funct3,
  input  logic [XLEN-1:0]              operand,
  input  logic [4:0]                   zimm,
  input  logic [XLEN-1:0]              old_value,
  input  logic [NUM_CSR_ADDR_BITS-1:0] csr_addr,
  output logic [XLEN-1:0]              write_data,
  output logic                         write_en,
  output logic                         illegal
);

  always_comb begin
    write_data = '0;
    write_en   = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_RW, F3_RWI: begin
        write_data = operand;
        write_en   = 1'b1;
      end
      F3_RS, F3_RSI: begin
        write_data = old_value | operand;
        write_en   = (zimm != 5'd0);
      end
      F3_RC, F3_RCI: begin
        write_data = old_value & ~operand;
        write_en   = (zimm != 5'd0);
      end
      default: illegal = 1'b1;
    endcase
    // zimm doubles as the rs1 index, so zimm==0 also covers rs1=x0 (pure read).
    if (write_en && csr_is_read_only(csr_addr[NUM_CSR_ADDR_BITS-1 -: 2])) begin
      illegal  = 1'b1;
      write_en = 1'b0;
    end
  end

endmodule

// File: rtl/csr_access_unit.sv
// Sequences one Zicsr instruction at a time against the CSR register file and merges FPU flags into fcsr.
// Pending flags are flushed before any new instruction is accepted, so flag updates never race software accesses.
module csr_access_unit
  import csr_pkg::*;
#(
  parameter int NUM_CSR_ADDR_BITS = 12,
  parameter int XLEN = 32
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         in_req_valid,
  output logic                         out_req_ready,
  input  logic [2:0]                   in_req_funct3,
  input  logic [NUM_CSR_ADDR_BITS-1:0] in_req_csr_addr,
  input  logic [XLEN-1:0]              in_req_rs1_data,
  input  logic [4:0]                   in_req_zimm,
  output logic                         out_rsp_valid,
  input  logic                         in_rsp_ready,
  output logic [XLEN-1:0]              out_rsp_rd_data,
  output logic                         out_rsp_illegal,
  input  logic                         in_fflags_valid,
  input  logic [4:0]                   in_fflags,
  output logic                         out_read_csr_enable,
  output logic [NUM_CSR_ADDR_BITS-1:0] out_read_csr_select,
  input  logic [XLEN-1:0]              in_read_csr_data,
  output logic                         out_write_csr_enable,
  output logic [NUM_CSR_ADDR_BITS-1:0] out_write_csr_select,
  output logic [XLEN-1:0]              out_write_csr_data,
  output logic                         out_read_fcsr_enable,
  input  logic [XLEN-1:0]              in_read_fcsr_data,
  output logic                         out_write_fcsr_enable,
  output logic [XLEN-1:0]              out_write_fcsr_data
);

  state_t                       state;
  logic [4:0]                   pending;
  logic [4:0]                   pending_next;
  logic [XLEN-1:0]              old_q;
  logic [XLEN-1:0]              operand_q;
  logic [2:0]                   funct3_q;
  logic [NUM_CSR_ADDR_BITS-1:0] addr_q;
  logic [4:0]                   zimm_q;

  logic                         read_en_q;
  logic [NUM_CSR_ADDR_BITS-1:0] read_sel_q;
  logic                         write_en_q;
  logic [NUM_CSR_ADDR_BITS-1:0] write_sel_q;
  logic [XLEN-1:0]              write_data_q;
  logic                         fcsr_en_q;
  logic                         rsp_valid_q;
  logic [XLEN-1:0]              rsp_data_q;
  logic                         rsp_illegal_q;

  logic                         idle;
  logic                         req_fire;
  logic [XLEN-1:0]              operand_in;
  logic [2:0]                   alu_funct3;
  logic [XLEN-1:0]              alu_operand;
  logic [4:0]                   alu_zimm;
  logic [NUM_CSR_ADDR_BITS-1:0] alu_addr;
  logic [XLEN-1:0]              alu_wdata;
  logic                         alu_wen;
  logic                         alu_illegal;

  assign idle       = (state == S_IDLE);
  assign req_fire   = idle && (pending == 5'd0) && in_req_valid;
  assign operand_in = in_req_funct3[2] ? {{(XLEN-5){1'b0}}, in_req_zimm} : in_req_rs1_data;

  // Flags seen during the FLUSH cycle are not in this merge, so they must survive into pending.
  assign pending_next = ((state == S_FLUSH) ? 5'd0 : pending) | (in_fflags_valid ? in_fflags : 5'd0);

  // In IDLE the ALU judges the offered request; afterwards it works on the latched instruction.
  assign alu_funct3  = idle ? in_req_funct3   : funct3_q;
  assign alu_operand = idle ? operand_in      : operand_q;
  assign alu_zimm    = idle ? in_req_zimm     : zimm_q;
  assign alu_addr    = idle ? in_req_csr_addr : addr_q;

  csr_rmw_alu #(
    .NUM_CSR_ADDR_BITS(NUM_CSR_ADDR_BITS),
    .XLEN(XLEN)
  ) u_alu (
    .funct3    (alu_funct3),
    .operand   (alu_operand),
    .zimm      (alu_zimm),
    .old_value (in_read_csr_data),
    .csr_addr  (alu_addr),
    .write_data(alu_wdata),
    .write_en  (alu_wen),
    .illegal   (alu_illegal)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= S_IDLE;
      pending       <= '0;
      old_q         <= '0;
      operand_q     <= '0;
      funct3_q      <= '0;
      addr_q        <= '0;
      zimm_q        <= '0;
      read_en_q     <= 1'b0;
      read_sel_q    <= '0;
      write_en_q    <= 1'b0;
      write_sel_q   <= '0;
      write_data_q  <= '0;
      fcsr_en_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_illegal_q <= 1'b0;
    end else begin
      pending      <= pending_next;
      read_en_q    <= 1'b0;
      read_sel_q   <= '0;
      write_en_q   <= 1'b0;
      write_sel_q  <= '0;
      write_data_q <= '0;
      fcsr_en_q    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_fire) begin
            funct3_q  <= in_req_funct3;
            addr_q    <= in_req_csr_addr;
            zimm_q    <= in_req_zimm;
            operand_q <= operand_in;
            old_q     <= '0;
            if (alu_illegal) begin
              rsp_valid_q   <= 1'b1;
              rsp_data_q    <= '0;
              rsp_illegal_q <= 1'b1;
              state         <= S_RESP;
            end else begin
              read_en_q  <= 1'b1;
              read_sel_q <= in_req_csr_addr;
              state      <= S_READ;
            end
          end else if (pending_next != 5'd0) begin
            fcsr_en_q <= 1'b1;
            state     <= S_FLUSH;
          end
        end
        S_FLUSH: state <= S_IDLE;
        S_READ: begin
          old_q      <= in_read_csr_data;
          write_en_q <= alu_wen;
          if (alu_wen) begin
            write_sel_q  <= addr_q;
            write_data_q <= alu_wdata;
          end
          state <= S_WRITE;
        end
        S_WRITE: begin
          rsp_valid_q   <= 1'b1;
          rsp_data_q    <= old_q;
          rsp_illegal_q <= 1'b0;
          state         <= S_RESP;
        end
        S_RESP: begin
          if (in_rsp_ready) begin
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_illegal_q <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign out_req_ready         = idle && (pending == 5'd0) && !RESET;
  assign out_rsp_valid         = rsp_valid_q;
  assign out_rsp_rd_data       = rsp_data_q;
  assign out_rsp_illegal       = rsp_illegal_q;
  assign out_read_csr_enable   = read_en_q;
  assign out_read_csr_select   = read_sel_q;
  assign out_write_csr_enable  = write_en_q;
  assign out_write_csr_select  = write_sel_q;
  assign out_write_csr_data    = write_data_q;
  assign out_read_fcsr_enable  = fcsr_en_q;
  assign out_write_fcsr_enable = fcsr_en_q;
  // The merge needs the live fcsr read, so this one output cannot be registered.
  assign out_write_fcsr_data   = fcsr_en_q ? (in_read_fcsr_data | {{(XLEN-5){1'b0}}, pending}) : '0;

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a transaction-level model and a per-cycle compare process.
module tb_csr_access_unit;

  logic        CLK;
  logic        RESET;
  logic        in_req_valid;
  logic        out_req_ready;
  logic [2:0]  in_req_funct3;
  logic [11:0] in_req_csr_addr;
  logic [31:0] in_req_rs1_data;
  logic [4:0]  in_req_zimm;
  logic        out_rsp_valid;
  logic        in_rsp_ready;
  logic [31:0] out_rsp_rd_data;
  logic        out_rsp_illegal;
  logic        in_fflags_valid;
  logic [4:0]  in_fflags;
  logic        out_read_csr_enable;
  logic [11:0] out_read_csr_select;
  logic [31:0] in_read_csr_data;
  logic        out_write_csr_enable;
  logic [11:0] out_write_csr_select;
  logic [31:0] out_write_csr_data;
  logic        out_read_fcsr_enable;
  logic [31:0] in_read_fcsr_data;
  logic        out_write_fcsr_enable;
  logic [31:0] out_write_fcsr_data;

  csr_access_unit dut (
    .CLK(CLK), .RESET(RESET),
    .in_req_valid(in_req_valid), .out_req_ready(out_req_ready),
    .in_req_funct3(in_req_funct3), .in_req_csr_addr(in_req_csr_addr),
    .in_req_rs1_data(in_req_rs1_data), .in_req_zimm(in_req_zimm),
    .out_rsp_valid(out_rsp_valid), .in_rsp_ready(in_rsp_ready),
    .out_rsp_rd_data(out_rsp_rd_data), .out_rsp_illegal(out_rsp_illegal),
    .in_fflags_valid(in_fflags_valid), .in_fflags(in_fflags),
    .out_read_csr_enable(out_read_csr_enable), .out_read_csr_select(out_read_csr_select),
    .in_read_csr_data(in_read_csr_data),
    .out_write_csr_enable(out_write_csr_enable), .out_write_csr_select(out_write_csr_select),
    .out_write_csr_data(out_write_csr_data),
    .out_read_fcsr_enable(out_read_fcsr_enable), .in_read_fcsr_data(in_read_fcsr_data),
    .out_write_fcsr_enable(out_write_fcsr_enable), .out_write_fcsr_data(out_write_fcsr_data)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Register-file environment: combinational reads, posedge writes, bench preload port.
  logic [31:0] mem [0:4095];
  logic [31:0] fcsr;
  logic        pl_en, pl_fcsr_en;
  logic [11:0] pl_addr;
  logic [31:0] pl_data;

  function automatic logic [31:0] rf_peek(input logic [11:0] a);
    if (a == 12'd1) return {27'd0, fcsr[4:0]};
    if (a == 12'd3) return fcsr;
    return mem[a];
  endfunction

  always_comb begin
    if (out_read_csr_select == 12'd1) in_read_csr_data = {27'd0, fcsr[4:0]};
    else if (out_read_csr_select == 12'd3) in_read_csr_data = fcsr;
    else in_read_csr_data = mem[out_read_csr_select];
  end
  assign in_read_fcsr_data = fcsr;

  always @(posedge CLK) begin
    if (out_write_csr_enable) mem[out_write_csr_select] <= out_write_csr_data;
    if (out_write_fcsr_enable) fcsr <= out_write_fcsr_data;
    if (pl_en) mem[pl_addr] <= pl_data;
    if (pl_fcsr_en) fcsr <= pl_data;
  end

  // Transaction-level model of the unit.
  typedef struct {
    int          acc;
    logic        ill;
    logic        wen;
    logic [11:0] addr;
    logic [31:0] old;
    logic [31:0] wdata;
  } txn_t;

  txn_t        q[$];
  txn_t        t, nt;
  logic [4:0]  acc;
  bit          idle_prev, has, exp_re, exp_we, exp_rv, exp_flush, accept;
  logic [31:0] opnd;

  always @(negedge CLK) begin
    if (RESET) begin
      q.delete();
      acc = 5'd0;
      idle_prev = 1'b1;
    end else begin
      has = (q.size() > 0);
      if (has) t = q[0];
      check("req_ready", out_req_ready, (!has && acc == 5'd0));
      exp_flush = idle_prev && (acc != 5'd0);
      check("fcsr_we", out_write_fcsr_enable, exp_flush);
      check("fcsr_re", out_read_fcsr_enable, exp_flush);
      check("fcsr_wdata", out_write_fcsr_data, exp_flush ? (fcsr | {27'd0, acc}) : 32'd0);
      exp_re = has && !t.ill && (cyc == t.acc + 1);
      exp_we = has && !t.ill && t.wen && (cyc == t.acc + 2);
      exp_rv = has && (cyc >= t.acc + (t.ill ? 1 : 3));
      check("rd_en", out_read_csr_enable, exp_re);
      check("rd_sel", out_read_csr_select, exp_re ? t.addr : 12'd0);
      check("wr_en", out_write_csr_enable, exp_we);
      check("wr_sel", out_write_csr_select, exp_we ? t.addr : 12'd0);
      check("wr_data", out_write_csr_data, exp_we ? t.wdata : 32'd0);
      check("rsp_valid", out_rsp_valid, exp_rv);
      check("rsp_rd", out_rsp_rd_data, (exp_rv && !t.ill) ? t.old : 32'd0);
      check("rsp_ill", out_rsp_illegal, exp_rv && t.ill);
      if (exp_rv && in_rsp_ready) void'(q.pop_front());
      accept = in_req_valid && out_req_ready;
      if (accept) begin
        nt.acc  = cyc;
        nt.addr = in_req_csr_addr;
        nt.old  = rf_peek(in_req_csr_addr);
        opnd    = in_req_funct3[2] ? {27'd0, in_req_zimm} : in_req_rs1_data;
        nt.ill  = 1'b0;
        nt.wen  = 1'b0;
        nt.wdata = 32'd0;
        case (in_req_funct3[1:0])
          2'b01: begin nt.wen = 1'b1; nt.wdata = opnd; end
          2'b10: begin nt.wen = (in_req_zimm != 5'd0); nt.wdata = nt.old | opnd; end
          2'b11: begin nt.wen = (in_req_zimm != 5'd0); nt.wdata = nt.old & ~opnd; end
          default: nt.ill = 1'b1;
        endcase
        if (nt.wen && in_req_csr_addr[11:10] == 2'b11) nt.ill = 1'b1;
        if (nt.ill) nt.wen = 1'b0;
        q.push_back(nt);
      end
      idle_prev = !has && !accept && !exp_flush;
      if (exp_flush) acc = 5'd0;
      if (in_fflags_valid) acc = acc | in_fflags;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic preload_fcsr(input logic [31:0] d);
    pl_fcsr_en = 1'b1; pl_data = d;
    step();
    pl_fcsr_en = 1'b0;
  endtask

  // Offers one instruction and returns just after the accepting edge (first cycle after acceptance).
  task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] r, input logic [4:0] z);
    int n;
    in_req_funct3 = f3; in_req_csr_addr = a; in_req_rs1_data = r; in_req_zimm = z;
    in_req_valid = 1'b1;
    n = 0;
    @(negedge CLK);
    while (!out_req_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!out_req_ready) begin
      errors++;
      $display("FAIL issue_timeout: ready never rose for addr 0x%03h", a);
    end
    step();
    in_req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    in_req_valid = 1'b0; in_req_funct3 = 3'd0; in_req_csr_addr = 12'd0;
    in_req_rs1_data = 32'd0; in_req_zimm = 5'd0; in_rsp_ready = 1'b1;
    in_fflags_valid = 1'b0; in_fflags = 5'd0;
    pl_en = 1'b0; pl_fcsr_en = 1'b0; pl_addr = 12'd0; pl_data = 32'd0;
    #2;
    check("rst_ready", out_req_ready, 0);
    check("rst_rsp_valid", out_rsp_valid, 0);
    check("rst_rd_en", out_read_csr_enable, 0);
    check("rst_wr_en", out_write_csr_enable, 0);
    check("rst_fcsr_we", out_write_fcsr_enable, 0);
    step(); step();
    RESET = 1'b0;
    step();

    // CSRRS 0x300, rs1=0xF0, old 0x0F
    preload(12'h300, 32'h0000_000F);
    issue(3'b010, 12'h300, 32'h0000_00F0, 5'd5);
    @(negedge CLK); check("t1_rd_en_c1", out_read_csr_enable, 1);
    @(negedge CLK); check("t1_wr_en_c2", out_write_csr_enable, 1);
    check("t1_wr_data", out_write_csr_data, 32'hFF);
    @(negedge CLK); check("t1_rsp_valid_c3", out_rsp_valid, 1);
    check("t1_rd_data", out_rsp_rd_data, 32'h0F);
    step();
    check("t1_mem", mem[12'h300], 32'hFF);

    // CSRRCI 0x300, zimm=0: read only
    preload(12'h300, 32'h55);
    issue(3'b111, 12'h300, 32'h0, 5'd0);
    @(negedge CLK); @(negedge CLK); check("t2_no_write", out_write_csr_enable, 0);
    @(negedge CLK); check("t2_rd_data", out_rsp_rd_data, 32'h55);
    step();
    check("t2_mem", mem[12'h300], 32'h55);

    // CSRRW to read-only space and reserved funct3
    issue(3'b001, 12'hC00, 32'h1, 5'd1);
    @(negedge CLK); check("t3_ill_valid_c1", out_rsp_valid, 1);
    check("t3_ill_flag", out_rsp_illegal, 1);
    check("t3_ill_rd", out_rsp_rd_data, 0);
    check("t3_ill_no_read", out_read_csr_enable, 0);
    step();
    issue(3'b100, 12'h300, 32'h0, 5'd1);
    @(negedge CLK); check("t3_f3_100_ill", out_rsp_illegal, 1);
    step();
    // Pure read of read-only space is legal
    preload(12'hC00, 32'h1234_5678);
    issue(3'b010, 12'hC00, 32'h0, 5'd0);
    @(negedge CLK); @(negedge CLK); @(negedge CLK);
    check("t3_ro_read_ill", out_rsp_illegal, 0);
    check("t3_ro_read_rd", out_rsp_rd_data, 32'h1234_5678);
    step();

    // Flag merge with a flag arriving during FLUSH
    preload_fcsr(32'h40);
    in_fflags_valid = 1'b1; in_fflags = 5'h01;
    step();
    in_fflags = 5'h04;
    @(negedge CLK); check("t4_flush1_we", out_write_fcsr_enable, 1);
    check("t4_flush1_data", out_write_fcsr_data, 32'h41);
    step();
    in_fflags_valid = 1'b0; in_fflags = 5'h00;
    check("t4_fcsr1", fcsr, 32'h41);
    @(negedge CLK); check("t4_gap_we", out_write_fcsr_enable, 0);
    @(negedge CLK); check("t4_flush2_data", out_write_fcsr_data, 32'h45);
    step();
    check("t4_fcsr2", fcsr, 32'h45);

    // CSRRS fflags with a flag pending at request time
    preload_fcsr(32'h0);
    in_fflags_valid = 1'b1; in_fflags = 5'h02;
    step();
    in_fflags_valid = 1'b0; in_fflags = 5'h00;
    in_req_funct3 = 3'b010; in_req_csr_addr = 12'd1; in_req_rs1_data = 32'd0; in_req_zimm = 5'd0;
    in_req_valid = 1'b1;
    @(negedge CLK); check("t5_ready_in_flush", out_req_ready, 0);
    check("t5_flush_we", out_write_fcsr_enable, 1);
    @(negedge CLK); check("t5_ready_after", out_req_ready, 1);
    step();
    in_req_valid = 1'b0;
    @(negedge CLK); @(negedge CLK); @(negedge CLK);
    check("t5_rd_fflags", out_rsp_rd_data, 32'h02);
    step();

    // Response stall with a competing request
    preload(12'h310, 32'h0000_AAAA);
    in_rsp_ready = 1'b0;
    issue(3'b001, 12'h310, 32'h0000_1234, 5'd3);
    in_req_funct3 = 3'b010; in_req_csr_addr = 12'h300; in_req_rs1_data = 32'd0; in_req_zimm = 5'd0;
    in_req_valid = 1'b1;
    @(negedge CLK); @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("t6_stall_valid", out_rsp_valid, 1);
      check("t6_stall_rd", out_rsp_rd_data, 32'h0000_AAAA);
      check("t6_stall_ready", out_req_ready, 0);
    end
    step();
    in_rsp_ready = 1'b1;
    @(negedge CLK); check("t6_release_ready", out_req_ready, 0);
    @(negedge CLK); check("t6_next_accept", out_req_ready, 1);
    step();
    in_req_valid = 1'b0;
    repeat (4) step();
    check("t6_mem", mem[12'h310], 32'h0000_1234);

    // Reset during WRITE, with a flag pending
    preload(12'h320, 32'h777);
    issue(3'b001, 12'h320, 32'hDEAD, 5'd1);
    in_fflags_valid = 1'b1; in_fflags = 5'h08;
    step();
    in_fflags_valid = 1'b0; in_fflags = 5'h00;
    check("t7_in_write", out_write_csr_enable, 1);
    RESET = 1'b1;
    #1;
    check("t7_rst_wr_en", out_write_csr_enable, 0);
    check("t7_rst_wr_data", out_write_csr_data, 0);
    check("t7_rst_ready", out_req_ready, 0);
    check("t7_rst_rd_en", out_read_csr_enable, 0);
    step(); step();
    RESET = 1'b0;
    repeat (4) step();
    check("t7_mem_kept", mem[12'h320], 32'h777);
    check("t7_flags_dropped", fcsr, 32'h02);
    check("t7_ready", out_req_ready, 1);
    check("drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
